// File: rtl/plant_pkg.sv
// Shared constants, M-sensor FSM states and saturating arithmetic for the tank plant emulator.
package plant_pkg;

  localparam int LVL_W      = 8;
  localparam int LVL_MAX    = 200;
  localparam int LVL_LOW    = 20;
  localparam int LVL_HIGH   = 180;
  localparam int FILL_RATE  = 4;
  localparam int DRAIN_RATE = 5;
  localparam int TMP_AMB    = 20;
  localparam int TMP_SET    = 60;
  localparam int TMP_MAX    = 100;
  localparam int COOL_DIV   = 4;
  localparam int MIX_TIME   = 10;
  localparam int M_HOLD     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } m_state_e;

  // One extra bit of headroom so a sum or difference never wraps before clamping.
  function automatic logic [LVL_W-1:0] sat_add(input logic [LVL_W-1:0] a,
                                               input logic [LVL_W-1:0] b,
                                               input logic [LVL_W-1:0] hi);
    logic [LVL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, hi}) return hi;
    return s[LVL_W-1:0];
  endfunction

  function automatic logic [LVL_W-1:0] sat_sub(input logic [LVL_W-1:0] a,
                                               input logic [LVL_W-1:0] b,
                                               input logic [LVL_W-1:0] lo);
    logic [LVL_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[LVL_W] || (d[LVL_W-1:0] < lo)) return lo;
    return d[LVL_W-1:0];
  endfunction

endpackage

// File: rtl/plant_um1bb_if.sv
// Controller <-> plant bundle: actuators and tick toward the plant, sensors and state back.
interface plant_um1bb_if #(parameter int LVL_W = 8);
  import plant_pkg::*;

  // Handshake: there is no valid/ready pair; tick is a one-cycle enable that
  // qualifies every state update, and actuator levels are sampled on tick cycles.
  logic             tick;
  logic             start;
  logic             sv;
  logic             cl;
  logic             cn;
  logic             de;
  logic             M;
  logic             SL;
  logic             SG;
  logic             LS;
  logic             LC;
  logic             ovf;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] temp;
  m_state_e         m_state;

  modport master (
    output tick, start, sv, cl, cn, de,
    input  M, SL, SG, LS, LC, ovf, level, temp, m_state
  );

  modport slave (
    input  tick, start, sv, cl, cn, de,
    output M, SL, SG, LS, LC, ovf, level, temp, m_state
  );

endinterface

// File: rtl/plant_sensor_dly.sv
// Tick-enabled two-stage delay line, one independent lane per bit.
module plant_sensor_dly #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  always_ff @(posedge ck) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else if (en) begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/plant_um1bb.sv
// Tank plant emulator: level, temperature, mixing and start-button models advanced on the 1 s tick.
// Define PLANT_SENSOR_DLY_EN to add a two-tick response lag on SL, SG, LS and LC.
module plant_um1bb
  import plant_pkg::*;
#(
  parameter int LVL_MAX    = plant_pkg::LVL_MAX,
  parameter int LVL_LOW    = plant_pkg::LVL_LOW,
  parameter int LVL_HIGH   = plant_pkg::LVL_HIGH,
  parameter int FILL_RATE  = plant_pkg::FILL_RATE,
  parameter int DRAIN_RATE = plant_pkg::DRAIN_RATE,
  parameter int TMP_AMB    = plant_pkg::TMP_AMB,
  parameter int TMP_SET    = plant_pkg::TMP_SET,
  parameter int TMP_MAX    = plant_pkg::TMP_MAX,
  parameter int COOL_DIV   = plant_pkg::COOL_DIV,
  parameter int MIX_TIME   = plant_pkg::MIX_TIME,
  parameter int M_HOLD     = plant_pkg::M_HOLD
) (
  input  logic          ck,
  input  logic          rst,
  plant_um1bb_if.slave  bus
);

  localparam int CD_W  = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
  localparam int MIX_W = $clog2(MIX_TIME + 1);
  localparam int H_W   = (M_HOLD > 1) ? $clog2(M_HOLD) : 1;

  localparam logic [LVL_W-1:0] L_MAX  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] L_LOW  = LVL_W'(LVL_LOW);
  localparam logic [LVL_W-1:0] L_HIGH = LVL_W'(LVL_HIGH);
  localparam logic [LVL_W-1:0] F_RATE = LVL_W'(FILL_RATE);
  localparam logic [LVL_W-1:0] D_RATE = LVL_W'(DRAIN_RATE);
  localparam logic [LVL_W-1:0] T_AMB  = LVL_W'(TMP_AMB);
  localparam logic [LVL_W-1:0] T_SET  = LVL_W'(TMP_SET);
  localparam logic [LVL_W-1:0] T_MAX  = LVL_W'(TMP_MAX);
  localparam logic [CD_W-1:0]  CD_END = CD_W'(COOL_DIV - 1);
  localparam logic [MIX_W-1:0] MIX_END = MIX_W'(MIX_TIME);
  localparam logic [H_W-1:0]   H_INIT = H_W'(M_HOLD - 1);

  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] temp;
  logic [CD_W-1:0]  cdiv;
  logic [MIX_W-1:0] mix;
  logic             ovf;
  m_state_e         state, state_n;
  logic [H_W-1:0]   hold, hold_n;
  logic             req, req_n;

  logic filling, draining, heating;
  assign filling  = bus.sv & ~bus.de;
  assign draining = bus.de & ~bus.sv;
  // Heating an empty tank is ignored, so it falls through to the cooling path.
  assign heating  = bus.cl & (level != '0);

  always_ff @(posedge ck) begin
    if (rst) begin
      level <= '0;
      temp  <= T_AMB;
      cdiv  <= '0;
      mix   <= '0;
      ovf   <= 1'b0;
    end else if (bus.tick) begin
      if (filling)       level <= sat_add(level, F_RATE, L_MAX);
      else if (draining) level <= sat_sub(level, D_RATE, '0);

      if (filling && (level == L_MAX)) ovf <= 1'b1;

      if (heating) begin
        temp <= sat_add(temp, LVL_W'(1), T_MAX);
        cdiv <= '0;
      end else if (cdiv == CD_END) begin
        cdiv <= '0;
        if (temp > T_AMB) temp <= temp - LVL_W'(1);
      end else begin
        cdiv <= cdiv + CD_W'(1);
      end

      if (bus.de)                                              mix <= '0;
      else if (bus.cn && (level != '0) && (mix != MIX_END))    mix <= mix + MIX_W'(1);
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      req   <= 1'b0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      req   <= req_n;
    end
  end

  // A start pulse landing between ticks is held in req until the next tick.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    req_n   = req;
    case (state)
      IDLE: begin
        if (bus.tick && (req || bus.start)) begin
          state_n = PRESS;
          hold_n  = H_INIT;
          req_n   = 1'b0;
        end else if (bus.start) begin
          req_n = 1'b1;
        end
      end
      PRESS: begin
        if (bus.tick) begin
          if (hold == '0) state_n = RELEASE;
          else            hold_n  = hold - H_W'(1);
        end
      end
      RELEASE: begin
        if (bus.tick && !bus.start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic sl_c, sg_c, ls_c, lc_c;
  assign sl_c = (level <= L_LOW);
  assign sg_c = (temp >= T_SET);
  assign ls_c = (level >= L_HIGH);
  assign lc_c = (mix == MIX_END);

`ifdef PLANT_SENSOR_DLY_EN
  logic [3:0] sens_q;
  plant_sensor_dly #(.W(4), .RST_VAL(4'b1000)) u_dly (
    .ck  (ck),
    .rst (rst),
    .en  (bus.tick),
    .d   ({sl_c, sg_c, ls_c, lc_c}),
    .q   (sens_q)
  );
  assign {bus.SL, bus.SG, bus.LS, bus.LC} = sens_q;
`else
  assign {bus.SL, bus.SG, bus.LS, bus.LC} = {sl_c, sg_c, ls_c, lc_c};
`endif

  assign bus.M       = (state == PRESS);
  assign bus.ovf     = ovf;
  assign bus.level   = level;
  assign bus.temp    = temp;
  assign bus.m_state = state;

endmodule

// File: tb/tb_plant_um1bb.sv
// Bench for plant_um1bb: directed scenarios plus random stimulus against a behavioural plant model.
module tb_plant_um1bb;
  import plant_pkg::*;

  logic ck = 1'b0;
  logic rst;
  always #5 ck = ~ck;

  plant_um1bb_if #(.LVL_W(8)) bus();

  plant_um1bb dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // requested input levels, applied at the next falling edge
  bit d_rst, d_start, d_sv, d_cl, d_cn, d_de;

  // behavioural plant model
  int mv_level, mv_temp, mv_cool, mv_mix, mv_ovf;
  int mv_left, mv_wait, mv_pend;
  int p1[4], p2[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  task automatic model_reset();
    mv_level = 0; mv_temp = 20; mv_cool = 0; mv_mix = 0; mv_ovf = 0;
    mv_left = 0; mv_wait = 0; mv_pend = 0;
    p1 = '{1, 0, 0, 0};
    p2 = '{1, 0, 0, 0};
  endtask

  // Called right after a rising edge with the inputs that edge sampled.
  task automatic model_step();
    int nl;
    if (rst) begin
      model_reset();
      return;
    end
    if (mv_left == 0 && !mv_wait && bus.start) mv_pend = 1;
    if (!bus.tick) return;
    p2 = p1;
    p1 = '{(mv_level <= 20), (mv_temp >= 60), (mv_level >= 180), (mv_mix == 10)};
    nl = mv_level;
    if (bus.sv && !bus.de) nl = imin(mv_level + 4, 200);
    if (bus.de && !bus.sv) nl = imax(mv_level - 5, 0);
    if (bus.sv && !bus.de && mv_level == 200) mv_ovf = 1;
    if (bus.cl && mv_level > 0) begin
      mv_temp = imin(mv_temp + 1, 100);
      mv_cool = 0;
    end else begin
      mv_cool++;
      if (mv_cool == 4) begin
        mv_cool = 0;
        if (mv_temp > 20) mv_temp--;
      end
    end
    if (bus.de) mv_mix = 0;
    else if (bus.cn && mv_level > 0) mv_mix = imin(mv_mix + 1, 10);
    if (mv_left > 0) begin
      mv_left--;
      if (mv_left == 0) mv_wait = 1;
    end else if (mv_wait) begin
      if (!bus.start) mv_wait = 0;
    end else if (mv_pend) begin
      mv_left = 3;
      mv_pend = 0;
    end
    mv_level = nl;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge.
  task automatic cyc(input bit t);
    @(negedge ck);
    rst       = d_rst;
    bus.tick  = t;
    bus.start = d_start;
    bus.sv    = d_sv;
    bus.cl    = d_cl;
    bus.cn    = d_cn;
    bus.de    = d_de;
    @(posedge ck);
    model_step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    d_rst = 1; d_start = 0; d_sv = 0; d_cl = 0; d_cn = 0; d_de = 0;
    cyc(1'b0);
    chk_on = 1'b1;
    d_rst = 0;
    cyc(1'b0);
  endtask

  always @(negedge ck) begin
    if (chk_on) begin
      check("M",     32'(bus.M),     32'(mv_left > 0));
      check("ovf",   32'(bus.ovf),   32'(mv_ovf));
      check("level", 32'(bus.level), 32'(mv_level));
      check("temp",  32'(bus.temp),  32'(mv_temp));
`ifdef PLANT_SENSOR_DLY_EN
      check("SL", 32'(bus.SL), 32'(p2[0]));
      check("SG", 32'(bus.SG), 32'(p2[1]));
      check("LS", 32'(bus.LS), 32'(p2[2]));
      check("LC", 32'(bus.LC), 32'(p2[3]));
`else
      check("SL", 32'(bus.SL), 32'(mv_level <= 20));
      check("SG", 32'(bus.SG), 32'(mv_temp >= 60));
      check("LS", 32'(bus.LS), 32'(mv_level >= 180));
      check("LC", 32'(bus.LC), 32'(mv_mix == 10));
`endif
    end
  end

  initial begin
    int mcnt;
    model_reset();
    rst = 1; bus.tick = 0; bus.start = 0; bus.sv = 0; bus.cl = 0; bus.cn = 0; bus.de = 0;

    // reset values
    do_reset();
    #1;
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_temp",  32'(bus.temp),  32'd20);
    check("rst_SL",    32'(bus.SL),    32'd1);
    check("rst_M",     32'(bus.M),     32'd0);

    // fill and overflow
    d_sv = 1;
    ticks(5);  #1; check("fill5_level", 32'(bus.level), 32'd20);  check("fill5_SL", 32'(bus.SL), 32'd1);
    ticks(1);  #1; check("fill6_level", 32'(bus.level), 32'd24);  check("fill6_SL", 32'(bus.SL), 32'd0);
    ticks(39); #1; check("fill45_level", 32'(bus.level), 32'd180); check("fill45_LS", 32'(bus.LS), 32'd1);
    ticks(5);  #1; check("fill50_level", 32'(bus.level), 32'd200); check("fill50_ovf", 32'(bus.ovf), 32'd0);
    ticks(1);  #1; check("fill51_ovf", 32'(bus.ovf), 32'd1);
    d_sv = 0;
    ticks(2);  #1; check("ovf_sticky", 32'(bus.ovf), 32'd1);

    // heat and cool
    do_reset();
    d_sv = 1; ticks(25); d_sv = 0;
    d_cl = 1; ticks(40); #1; check("heat_temp", 32'(bus.temp), 32'd60); check("heat_SG", 32'(bus.SG), 32'd1);
    d_cl = 0; ticks(4);  #1; check("cool_temp", 32'(bus.temp), 32'd59); check("cool_SG", 32'(bus.SG), 32'd0);

    // mix then drain
    d_cn = 1; ticks(10); #1; check("mix_LC", 32'(bus.LC), 32'd1);
    d_cn = 0; d_de = 1; ticks(1); #1;
    check("drain_LC", 32'(bus.LC), 32'd0);
    check("drain_level", 32'(bus.level), 32'd95);
    d_de = 0;

    // start pulse between ticks, then start held high
    do_reset();
    d_start = 1; cyc(1'b0); d_start = 0; cyc(1'b0);
    mcnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1); #1; if (bus.M) mcnt++;
      cyc(1'b0);
    end
    check("start_pulse_ticks", 32'(mcnt), 32'd3);
    d_start = 1; mcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1); #1; if (bus.M) mcnt++;
      cyc(1'b0);
    end
    check("start_held_ticks", 32'(mcnt), 32'd3);
    d_start = 0; ticks(2);

    // reset while the start sensor is pressed
    do_reset();
    d_sv = 1; ticks(30); d_sv = 0;
    d_cl = 1; ticks(50); d_cl = 0;
    d_start = 1; cyc(1'b0); d_start = 0;
    cyc(1'b1); #1;
    check("pre_rst_M", 32'(bus.M), 32'd1);
    check("pre_rst_level", 32'(bus.level), 32'd120);
    check("pre_rst_temp", 32'(bus.temp), 32'd70);
    d_rst = 1; cyc(1'b0); #1;
    check("mid_rst_M", 32'(bus.M), 32'd0);
    check("mid_rst_level", 32'(bus.level), 32'd0);
    check("mid_rst_temp", 32'(bus.temp), 32'd20);
    check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    d_rst = 0;

    // random operation
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        d_sv = 1'($urandom_range(0, 1));
        d_cl = 1'($urandom_range(0, 1));
        d_cn = 1'($urandom_range(0, 1));
        d_de = ($urandom_range(0, 3) == 0);
      end
      d_start = ($urandom_range(0, 15) == 0);
      d_rst   = ($urandom_range(0, 599) == 0);
      cyc($urandom_range(0, 2) == 0);
    end
    d_rst = 0;
    cyc(1'b0);
    @(negedge ck);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
